// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB register slave: register map, bit positions
// and the APB phase encoding.
package apb_slave_pkg;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_STATUS   = 3'd1;
  localparam logic [2:0] IDX_LOAD     = 3'd2;
  localparam logic [2:0] IDX_COUNT    = 3'd3;
  localparam logic [2:0] IDX_SCRATCH0 = 3'd4;
  localparam logic [2:0] IDX_SCRATCH1 = 3'd5;
  localparam logic [2:0] IDX_SCRATCH2 = 3'd6;
  localparam logic [2:0] IDX_SCRATCH3 = 3'd7;

  localparam logic [31:0] OFF_CTRL     = 32'h00;
  localparam logic [31:0] OFF_STATUS   = 32'h04;
  localparam logic [31:0] OFF_LOAD     = 32'h08;
  localparam logic [31:0] OFF_COUNT    = 32'h0C;
  localparam logic [31:0] OFF_SCRATCH0 = 32'h10;
  localparam logic [31:0] OFF_SCRATCH1 = 32'h14;
  localparam logic [31:0] OFF_SCRATCH2 = 32'h18;
  localparam logic [31:0] OFF_SCRATCH3 = 32'h1C;

  localparam int CTRL_TMR_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int STAT_EXPIRED = 0;
  localparam int STAT_PERR    = 1;

  typedef enum logic {
    IDLE       = 1'b0,
    SETUP_SEEN = 1'b1
  } phase_e;

endpackage

// File: rtl/apb_timer.sv
// Reloadable down-counter: loads on start, counts while enabled, and on reaching
// zero pulses expire and reloads from load_val.
module apb_timer #(
  parameter int          TIMER_W    = 32,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic               Hclk,
  input  logic               Hreset,
  input  logic               en_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               expire_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // A stop in the same cycle as zero suppresses the expiry and holds the count.
  always_comb begin
    count_d  = count_q;
    expire_o = 1'b0;
    if (start_i) begin
      count_d = load_val_i;
    end else if (en_i && !stop_i) begin
      if (count_q == '0) begin
        expire_o = 1'b1;
        count_d  = load_val_i;
      end else begin
        count_d = count_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) count_q <= RESET_LOAD[TIMER_W-1:0];
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/apb_slave_regs.sv
// APB2 register slave: tracks SETUP/ACCESS, decodes 8 word registers, flags
// protocol violations and hosts a down-counter timer with a sticky expiry.
module apb_slave_regs
  import apb_slave_pkg::*;
#(
  parameter int          SEL_IDX    = 0,
  parameter int          TIMER_W    = 32,
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        irq,
  output logic        proto_err
);

  phase_e             phase_q, phase_d;
  logic [2:0]         addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [1:0]         stat_q, stat_d;
  logic [TIMER_W-1:0] load_q, load_d;
  logic [3:0][31:0]   scratch_q, scratch_d;

  logic               sel, setup, acc_ok, perr_set, wr_en, rd_en;
  logic               tmr_start, tmr_stop, tmr_expire;
  logic [TIMER_W-1:0] count;
  logic [31:0]        rdata;

  // Phase tracking. In SETUP_SEEN anything but the matching ACCESS is an
  // error; a fresh SETUP there is still latched so the next ACCESS can land.
  always_comb begin
    sel      = Pselx[SEL_IDX];
    setup    = sel & ~Penable;
    acc_ok   = (phase_q == SETUP_SEEN) & sel & Penable &
               (Paddr[4:2] == addr_q) & (Pwrite == wr_q);
    perr_set = (phase_q == IDLE) ? (sel & Penable) : ~acc_ok;
    wr_en    = acc_ok & wr_q;
    rd_en    = acc_ok & ~wr_q;
    phase_d  = setup ? SETUP_SEEN : IDLE;
    addr_d   = setup ? Paddr[4:2] : addr_q;
    wr_d     = setup ? Pwrite : wr_q;
  end

  always_comb begin
    tmr_start = 1'b0;
    tmr_stop  = 1'b0;
    if (wr_en && addr_q == IDX_CTRL) begin
      tmr_start = Pwdata[CTRL_TMR_EN] & ~ctrl_q[CTRL_TMR_EN];
      tmr_stop  = ~Pwdata[CTRL_TMR_EN] & ctrl_q[CTRL_TMR_EN];
    end
  end

  // Hardware sets are OR-ed in after the W1C so they win a same-cycle clear.
  always_comb begin
    ctrl_d    = ctrl_q;
    stat_d    = stat_q;
    load_d    = load_q;
    scratch_d = scratch_q;
    if (wr_en) begin
      case (addr_q)
        IDX_CTRL:   ctrl_d = Pwdata[1:0];
        IDX_STATUS: stat_d = stat_q & ~Pwdata[1:0];
        IDX_LOAD:   load_d = Pwdata[TIMER_W-1:0];
        IDX_COUNT:  ;
        default:    scratch_d[addr_q[1:0]] = Pwdata;
      endcase
    end
    stat_d[STAT_EXPIRED] = stat_d[STAT_EXPIRED] | tmr_expire;
    stat_d[STAT_PERR]    = stat_d[STAT_PERR] | perr_set;
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      phase_q   <= IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      ctrl_q    <= '0;
      stat_q    <= '0;
      load_q    <= RESET_LOAD[TIMER_W-1:0];
      scratch_q <= '0;
    end else begin
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      ctrl_q    <= ctrl_d;
      stat_q    <= stat_d;
      load_q    <= load_d;
      scratch_q <= scratch_d;
    end
  end

  apb_timer #(
    .TIMER_W   (TIMER_W),
    .RESET_LOAD(RESET_LOAD)
  ) u_timer (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .en_i      (ctrl_q[CTRL_TMR_EN]),
    .load_val_i(load_q),
    .start_i   (tmr_start),
    .stop_i    (tmr_stop),
    .count_o   (count),
    .expire_o  (tmr_expire)
  );

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr_q)
        IDX_CTRL:   rdata = {30'b0, ctrl_q};
        IDX_STATUS: rdata = {30'b0, stat_q};
        IDX_LOAD:   rdata = 32'(load_q);
        IDX_COUNT:  rdata = 32'(count);
        default:    rdata = scratch_q[addr_q[1:0]];
      endcase
    end
  end

  assign Prdata    = rdata;
  assign irq       = ctrl_q[CTRL_IRQ_EN] & stat_q[STAT_EXPIRED];
  assign proto_err = stat_q[STAT_PERR];

  logic unused_bits;
  assign unused_bits = ^{Pselx, Paddr[31:5], Paddr[1:0], Pwdata};

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: APB transfers, timer, W1C, protocol errors.
module tb_apb_slave_regs;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] Prdata;
  logic        irq, proto_err;

  int n_pass  = 0;
  int n_total = 0;
  logic [2:0]  psel_v = 3'b001;
  logic [31:0] rd, sd;

  always #5 Hclk = ~Hclk;

  apb_slave_regs dut (
    .Hclk     (Hclk),
    .Hreset   (Hreset),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .irq      (irq),
    .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Each transfer starts in the current cycle (just after an edge) with SETUP,
  // ACCESS follows, and the task returns just after the edge ending ACCESS.
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    Pselx = psel_v; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(posedge Hclk); #1 Pselx = 3'b000; Penable = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic [31:0] s);
    Pselx = psel_v; Penable = 1'b0; Pwrite = 1'b0; Paddr = a; Pwdata = '0;
    @(negedge Hclk); s = Prdata;
    @(posedge Hclk); #1 Penable = 1'b1;
    @(negedge Hclk); d = Prdata;
    @(posedge Hclk); #1 Pselx = 3'b000; Penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d, s;
    apb_rd(a, d, s);
    check(tag, d, exp);
  endtask

  initial begin
    Hreset = 1'b1; Pselx = '0; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
    repeat (2) @(posedge Hclk);
    #1;
    check("rst_prdata", Prdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_perr", {31'b0, proto_err}, 32'h0);
    Hreset = 1'b0;
    rd_chk("rst_ctrl", 32'h00, 32'h0);
    rd_chk("rst_status", 32'h04, 32'h0);
    rd_chk("rst_load", 32'h08, 32'hFFFF_FFFF);
    rd_chk("rst_count", 32'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_scratch3", 32'h1C, 32'h0);

    // 1: scratch write/read
    apb_wr(32'h14, 32'hDEAD_BEEF);
    apb_rd(32'h14, rd, sd);
    check("scr1_access", rd, 32'hDEAD_BEEF);
    check("scr1_setup0", sd, 32'h0);
    check("scr1_perr", {31'b0, proto_err}, 32'h0);

    // 2: LOAD=3, start with irq. Cycle c1 (after CTRL commit) holds COUNT=3.
    apb_wr(32'h08, 32'h3);
    apb_wr(32'h00, 32'h3);
    rd_chk("cnt_c2", 32'h0C, 32'd2);
    rd_chk("cnt_c4", 32'h0C, 32'd0);
    check("irq_c5", {31'b0, irq}, 32'h1);
    rd_chk("stat_c6", 32'h04, 32'h1);
    @(posedge Hclk); #1;
    rd_chk("cnt_reload_c9", 32'h0C, 32'd3);
    apb_wr(32'h04, 32'h1);
    check("irq_cleared_c12", {31'b0, irq}, 32'h0);
    @(posedge Hclk); #1;
    check("irq_again_c13", {31'b0, irq}, 32'h1);
    apb_wr(32'h00, 32'h0);
    apb_wr(32'h04, 32'h1);
    rd_chk("stat_off", 32'h04, 32'h0);
    check("irq_off", {31'b0, irq}, 32'h0);

    // 3: ACCESS without SETUP
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h5;
    @(posedge Hclk); #1 Pselx = '0; Penable = 1'b0;
    check("nosetup_perr", {31'b0, proto_err}, 32'h1);
    rd_chk("nosetup_scr0", 32'h10, 32'h0);
    apb_wr(32'h04, 32'h2);
    check("perr_w1c", {31'b0, proto_err}, 32'h0);

    // 4: address changes between SETUP and ACCESS
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'h1234;
    @(posedge Hclk); #1 Penable = 1'b1; Paddr = 32'h18;
    @(posedge Hclk); #1 Pselx = '0; Penable = 1'b0;
    check("addrchg_perr", {31'b0, proto_err}, 32'h1);
    rd_chk("addrchg_scr0", 32'h10, 32'h0);
    rd_chk("addrchg_scr2", 32'h18, 32'h0);
    apb_wr(32'h04, 32'h2);
    psel_v = 3'b010;
    apb_wr(32'h10, 32'h77);
    apb_rd(32'h10, rd, sd);
    check("othersel_prdata", rd, 32'h0);
    psel_v = 3'b001;
    rd_chk("othersel_scr0", 32'h10, 32'h0);
    check("othersel_perr", {31'b0, proto_err}, 32'h0);

    // 5: LOAD=0 expires every cycle; W1C loses to a same-cycle expiry
    apb_wr(32'h08, 32'h0);
    apb_wr(32'h00, 32'h1);
    apb_wr(32'h04, 32'h1);
    rd_chk("w1c_vs_set", 32'h04, 32'h1);
    check("irq_masked", {31'b0, irq}, 32'h0);
    apb_wr(32'h00, 32'h0);
    apb_wr(32'h04, 32'h3);
    rd_chk("stat_cleared", 32'h04, 32'h0);

    // 6: reset lands between SETUP and ACCESS of CTRL=3
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h00; Pwdata = 32'h3;
    @(negedge Hclk); Hreset = 1'b1;
    @(posedge Hclk); #1 Hreset = 1'b0; Penable = 1'b1;
    @(posedge Hclk); #1 Pselx = '0; Penable = 1'b0;
    check("rstmid_perr", {31'b0, proto_err}, 32'h1);
    rd_chk("rstmid_ctrl", 32'h00, 32'h0);
    rd_chk("rstmid_count", 32'h0C, 32'hFFFF_FFFF);
    rd_chk("rstmid_load", 32'h08, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_slave_regs.md
Name: apb_slave_regs

Overview:
APB2 responder that sits on one Pselx line of the AHB-to-APB bridge and completes the bus from the peripheral side. It tracks the bridge's SETUP/ACCESS sequence, decodes a bank of 8 word registers, returns read data in the ACCESS cycle, and flags protocol violations. It also hosts a reloadable down-counter timer with a sticky expiry flag and an interrupt, giving the bridge a real target to verify against.

Parameters:
SEL_IDX, 0, index of the Pselx bit (0..2) that selects this slave
TIMER_W, 32, timer counter width (1..32); LOAD/COUNT are zero-extended on read
RESET_LOAD, 32'hFFFF_FFFF, reset value of LOAD (truncated to TIMER_W)

Ports:
Hclk  in  1  clock, shared with the bridge
Hreset  in  1  reset, asynchronous, active-high
Pselx  in  3  APB selects; only bit SEL_IDX is used
Penable  in  1  APB enable (ACCESS phase)
Pwrite  in  1  1 = write, 0 = read
Paddr  in  32  byte address; only [4:2] is decoded
Pwdata  in  32  write data
Prdata  out  32  read data, valid in the ACCESS cycle
irq  out  1  CTRL.irq_en & STATUS.expired
proto_err  out  1  mirror of STATUS.perr

Behaviour:
- Reset (async, Hreset=1): all registers reset as listed; phase=IDLE; Prdata=0; irq=0; proto_err=0; any in-flight write is discarded.
- Let sel = Pselx[SEL_IDX]. The phase register holds one of IDLE, SETUP_SEEN.
- SETUP cycle: sel & !Penable. Latch Paddr[4:2] and Pwrite; go to SETUP_SEEN.
- Valid ACCESS cycle: phase==SETUP_SEEN & sel & Penable & Paddr[4:2]==latched & Pwrite==latched. Go to IDLE, or to SETUP_SEEN if this is back-to-back SETUP (not possible in APB2, so IDLE).
- Protocol errors, which set STATUS.perr and drive phase to IDLE with no register effect:
  - sel & Penable while phase==IDLE.
  - In SETUP_SEEN: !sel, or sel & !Penable, or an address/direction mismatch.
  - Exception: in SETUP_SEEN, sel & !Penable is treated as a new SETUP (relatch, stay in SETUP_SEEN) as well as raising perr.
- Writes commit on the Hclk edge that ends a valid write ACCESS. There are zero wait states; the bridge has no Pready.
- Reads: Prdata is combinational from the addressed register during a valid read ACCESS; otherwise Prdata=0.
- Register map (word index, offset):
  - 0 CTRL 0x00 RW: [0] tmr_en, [1] irq_en, other bits read 0; reset 0.
  - 1 STATUS 0x04: [0] expired, [1] perr. Write-1-to-clear; reset 0.
  - 2 LOAD 0x08 RW: reset RESET_LOAD.
  - 3 COUNT 0x0C RO: writes ignored; reset RESET_LOAD.
  - 4..7 SCRATCH0..3 0x10..0x1C RW: reset 0.
- Timer:
  - On the edge where tmr_en goes 0->1 (by a CTRL write), COUNT<=LOAD.
  - While tmr_en=1 and COUNT!=0: COUNT decrements by 1 per cycle.
  - While tmr_en=1 and COUNT==0: STATUS.expired<=1 and COUNT<=LOAD. LOAD=0 therefore expires every cycle.
  - tmr_en=0: COUNT holds its value.
  - A LOAD write takes effect at the next reload only; the running count is unaffected.
- Simultaneous events:
  - Hardware set of expired or perr in the same cycle as a W1C of that bit: the set wins, bit stays 1.
  - A write to CTRL clearing tmr_en in the same cycle as COUNT==0: no expiry, COUNT holds 0.
- Arithmetic: COUNT is TIMER_W bits and does not wrap below 0 (reload occurs instead). Pwdata bits above TIMER_W are ignored for LOAD.
- Paddr[1:0] and Paddr[31:5] are ignored; decode is done upstream by the bridge's Pselx.

Decomposition:
- Shared package apb_slave_pkg holds:
  - register word indices and offsets (CTRL..SCRATCH3);
  - CTRL/STATUS bit positions;
  - the phase enum (IDLE, SETUP_SEEN).
- One sub-module is natural: apb_timer.
  - Inputs: Hclk, Hreset, en, load_val, start pulse, stop-this-cycle.
  - Outputs: count, expire pulse.
  - The register bank and APB phase tracker stay in apb_slave_regs.

Test Plan:
1. Write SCRATCH1 (Paddr=0x14, Pwdata=32'hDEAD_BEEF) via SETUP then ACCESS; then read 0x14 -> Prdata=32'hDEAD_BEEF in the read ACCESS cycle, Prdata=0 in its SETUP cycle; proto_err stays 0.
2. Write LOAD=3, then CTRL=3 -> COUNT reads 3,2,1,0 on successive cycles; expired=1 and irq=1 on the cycle after COUNT==0; COUNT reloads to 3; write STATUS=1 -> expired clears, irq=0 until the next expiry.
3. Drive sel & Penable with no preceding SETUP, write SCRATCH0=5 -> SCRATCH0 stays 0, proto_err=1; write STATUS=2 -> proto_err=0.
4. SETUP to 0x10, then ACCESS with Paddr changed to 0x18 -> neither SCRATCH0 nor SCRATCH2 changes; perr=1. Repeat with Pselx bit != SEL_IDX -> no response, Prdata=0.
5. LOAD=0, tmr_en=1, and a W1C of STATUS.expired on a cycle when expiry also fires -> expired remains 1.
6. Assert Hreset between SETUP and ACCESS of a CTRL write of 3 -> CTRL=0, COUNT=RESET_LOAD, phase=IDLE; the following ACCESS without SETUP sets perr.
